instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage feeding instruction_decode. Holds the PC and issues word reads to
//  instruction memory over a valid/ready request channel with an in-order response.
//  Buffers fetched words in a small FIFO and hands {instr_pc, instr_data} downstream
//  with valid/ready. Branch/jump redirects flush the stage and restart at a new PC.
// PARAMETERS
//  WIDTH       32            address/instruction width in bits
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  FIFO_DEPTH  2             output buffer entries (>=1)
// PORTS
//  clk             in   1      clock (all logic on rising edge)
//  rst_n           in   1      async active-low reset
//  imem_req_valid  out  1      fetch request valid
//  imem_req_ready  in   1      memory accepts request this cycle
//  imem_req_addr   out  WIDTH  fetch address (word aligned, [1:0]=0)
//  imem_rsp_valid  in   1      read data valid (one per accepted req, in order)
//  imem_rsp_data   in   WIDTH  read data
//  redirect_valid  in   1      redirect fetch to redirect_pc (flush)
//  redirect_pc     in   WIDTH  new PC; bits [1:0] ignored (forced 0)
//  instr_valid     out  1      instruction available to decode
//  instr_ready     in   1      decode consumes instruction this cycle
//  instr_data      out  WIDTH  instruction word -> instruction_decode.instruction
//  instr_pc        out  WIDTH  PC of instr_data
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_PC, state=REQ, FIFO empty; imem_req_valid=0,
//   imem_req_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
//  One clock domain; one outstanding memory request maximum.
//  FSM states:
//   REQ : imem_req_valid = (fifo_count < FIFO_DEPTH); addr = pc.
//         On valid&ready: pc <= pc+4 (wraps mod 2^WIDTH), latch req pc, -> WAIT.
//   WAIT: imem_req_valid=0. On imem_rsp_valid: push {req pc, rsp_data}, -> REQ.
//   DROP: imem_req_valid=0. On imem_rsp_valid: discard data, -> REQ.
//  Redirect (highest priority, any state): FIFO flushed (instr_valid=0 next cycle),
//   pc <= {redirect_pc[WIDTH-1:2],2'b00}. Next state:
//   REQ without handshake -> REQ; REQ with handshake same cycle -> DROP (old-addr
//   req is in flight); WAIT without rsp -> DROP; WAIT with rsp same cycle -> REQ,
//   rsp discarded; DROP without rsp -> DROP; DROP with rsp -> REQ.
//  Redirect when req valid but not ready: address changes to new pc next cycle
//   (only case where an unaccepted request may change).
//  Request stability otherwise: while imem_req_valid=1 and ready=0, addr held.
//  FIFO: registered; push in cycle N -> instr_valid in N+1. Pop on
//   instr_valid&instr_ready. Push and pop same cycle allowed (count unchanged).
//   Space is checked at request issue, so a response never hits a full FIFO.
//  instr_data/instr_pc: head entry; hold stable while instr_valid&!instr_ready.
//  Latency: redirect at cycle N -> first request with new pc at N+1 (if no
//   response pending), memory rsp at cycle M -> instr_valid at M+1.
//  Throughput: 1 instr per 2 cycles with 1-cycle memory (single outstanding).
//  rsp_valid in REQ state (protocol violation): ignored.
//  Reset mid-operation: all state cleared immediately; in-flight rsp after
//   reset release is not expected (memory reset together).
// TESTING
//  1 Reset release, ready=1, 1-cycle rsp returning addr as data -> req addrs
//    0,4,8..; decode sees (pc=0,data=0),(4,4),(8,8) in order.
//  2 instr_ready=0 with FIFO_DEPTH=2 -> after 2 pushes imem_req_valid=0; no loss;
//    raise ready -> entries drain in order, fetch resumes at pc 8.
//  3 Redirect to 0x103 during WAIT -> pending rsp dropped, FIFO flushed, next req
//    addr=0x100, instr_pc of next output = 0x100.
//  4 Redirect in same cycle as rsp_valid -> rsp not delivered; next req at new pc.
//  5 imem_req_ready=0 for 5 cycles -> addr/valid held stable; redirect during stall
//    -> addr switches to redirect pc next cycle, no DROP.
//  6 pc=0xFFFF_FFFC fetched -> next addr wraps to 0x0; rst_n low mid-WAIT ->
//    outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder and instruction-memory fetch engine.
// Issues one word request at a time, buffers returned words in a small FIFO and
// presents {instr_pc, instr_data} to decode. A redirect flushes everything and
// restarts fetching at the (word-aligned) redirect target.
//
// Handshake semantics (every valid/ready pair in this block): a transfer happens
// on a rising edge where valid and ready are both 1; once valid is raised it and
// its payload stay unchanged until the transfer. The single exception is a
// redirect, which may retarget a request that has not been accepted yet.
module instruction_fetch #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

    // REQ: may issue a request; WAIT: response owed to the FIFO;
    // DROP: response owed but belongs to a flushed stream.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // Fetch control registers
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   req_pc_q, req_pc_d;
    logic               req_valid_q, req_valid_d;

    // Output buffer registers
    logic [WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               req_fire;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   redirect_target;

    // Low two bits of the redirect target are discarded by design.
    logic               unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[WIDTH-1:2], 2'b00};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_C) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshake decode: request valid is only ever raised in REQ
    assign req_fire = req_valid_q & imem_req_ready;
    assign pop      = (count_q != '0) & instr_ready;

    // Next-state logic for the fetch FSM, PC and buffer bookkeeping
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    pc_d     = pc_q + WIDTH'(4);
                    req_pc_d = pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect wins over everything: retarget PC, flush, and remember
        // whether a stale response is still owed by memory.
        if (redirect_valid) begin
            push = 1'b0;
            pc_d = redirect_target;
            case (state_q)
                ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Space is reserved at issue time so a response never meets a full buffer.
        req_valid_d = (state_d == ST_REQ) && (count_d < DEPTH_C);
    end

    // Fetch FSM state, PC and registered request valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Output buffer storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= req_pc_q;
                fifo_data_q[wr_ptr_q] <= imem_rsp_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (count_q != '0);
    assign instr_data     = fifo_data_q[rd_ptr_q];
    assign instr_pc       = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: memory responder plus scoreboard built from
// the stage's externally visible rules, and directed/random scenario tasks.
module tb_instruction_fetch;
  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [W-1:0] imem_rsp_data = '0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [W-1:0] instr_data;
  logic [W-1:0] instr_pc;

  instruction_fetch #(.WIDTH(W), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // scoreboard state
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   pop_log[$];
  logic [W-1:0]   acc_log[$];
  int             acc_count = 0;
  logic [W-1:0]   exp_fetch = RST_PC;
  int             epoch = 0;
  bit             out_busy = 0;
  int             out_epoch = 0;
  logic [W-1:0]   out_addr = '0;
  bit             prev_stall = 0;
  logic [W-1:0]   prev_addr = '0;
  bit             prev_hold = 0;
  logic [W-1:0]   prev_ipc = '0;
  logic [W-1:0]   prev_idata = '0;

  // memory model state
  bit             mem_busy = 0;
  int             mem_cnt = 0;
  logic [W-1:0]   mem_addr = '0;
  int             mem_lat = 1;
  bit             data_is_addr = 1;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (data_is_addr) return a;
    return a ^ 32'hC3A5_0F1E ^ {a[15:0], a[31:16]};
  endfunction

  // Memory responder and scoreboard: observe at negedge what the next edge will do
  initial begin : mem_and_scoreboard
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        out_busy = 0;
        mem_busy = 0;
        epoch = 0;
        exp_fetch = RST_PC;
        prev_stall = 0;
        prev_hold = 0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr)
            $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
          else n_pass++;
        end
        if (prev_hold) begin
          n_checks++;
          if (instr_valid !== 1'b1 || instr_pc !== prev_ipc || instr_data !== prev_idata)
            $display("FAIL instr_hold: valid=%b pc=%h data=%h, required valid=1 pc=%h data=%h", instr_valid, instr_pc, instr_data, prev_ipc, prev_idata);
          else n_pass++;
        end
        if (instr_valid && instr_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL instr_out: got pc=%h data=%h, required nothing", instr_pc, instr_data);
          end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr_data} !== e)
              $display("FAIL instr_out: got pc=%h data=%h, required pc=%h data=%h", instr_pc, instr_data, e[2*W-1:W], e[W-1:0]);
            else n_pass++;
          end
          pop_log.push_back(instr_pc);
        end
        if (imem_rsp_valid) begin
          if (out_busy && !redirect_valid && out_epoch == epoch)
            exp_q.push_back({out_addr, mem_word(out_addr)});
          out_busy = 0;
        end
        if (imem_req_valid && imem_req_ready) begin
          n_checks++;
          if (imem_req_addr !== exp_fetch || out_busy)
            $display("FAIL req_addr: got %h (outstanding=%0d), required %h with none outstanding", imem_req_addr, out_busy, exp_fetch);
          else n_pass++;
          out_busy = 1;
          out_addr = exp_fetch;
          out_epoch = epoch;
          exp_fetch = exp_fetch + 32'd4;
          acc_count++;
          acc_log.push_back(imem_req_addr);
          mem_busy = 1;
          mem_cnt = mem_lat;
          mem_addr = imem_req_addr;
        end
        if (redirect_valid) begin
          epoch++;
          exp_q.delete();
          exp_fetch = {redirect_pc[W-1:2], 2'b00};
        end
        prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr = imem_req_addr;
        prev_hold = instr_valid && !instr_ready && !redirect_valid;
        prev_ipc = instr_pc;
        prev_idata = instr_data;
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst_n && mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = mem_word(mem_addr);
          mem_busy = 0;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
    pop_log.delete();
    acc_log.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pop_log.size() < n && k < budget) begin
      step(1);
      k++;
    end
  endtask

  task automatic do_redirect(input logic [W-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step(1);
    redirect_valid = 1'b0;
    pop_log.delete();
    acc_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); else n_pass++;
    n_checks++; if (imem_req_addr !== RST_PC) $display("FAIL rst_req_addr: got %h, required %h", imem_req_addr, RST_PC); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b, required 0", instr_valid); else n_pass++;
    n_checks++; if (instr_data !== '0) $display("FAIL rst_instr_data: got %h, required 0", instr_data); else n_pass++;
    n_checks++; if (instr_pc !== '0) $display("FAIL rst_instr_pc: got %h, required 0", instr_pc); else n_pass++;
  endtask

  task automatic test_sequential();
    int c0;
    data_is_addr = 1; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    wait_pops(3, 50);
    n_checks++;
    if (pop_log.size() < 3) $display("FAIL seq_timeout: got %0d instrs, required 3", pop_log.size());
    else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8)
      $display("FAIL seq_order: got %h %h %h, required 0 4 8", pop_log[0], pop_log[1], pop_log[2]);
    else n_pass++;
    c0 = pop_log.size();
    step(40);
    n_checks++;
    if (pop_log.size() - c0 < 19 || pop_log.size() - c0 > 21)
      $display("FAIL seq_throughput: got %0d instrs in 40 cycles, required 19..21", pop_log.size() - c0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int a0;
    data_is_addr = 0; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    a0 = acc_count;
    step(15);
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b, required 0", imem_req_valid); else n_pass++;
    n_checks++; if (acc_count - a0 !== 2) $display("FAIL bp_req_count: got %0d, required 2", acc_count - a0); else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0))
      $display("FAIL bp_head: got valid=%b pc=%h data=%h, required 1 0 %h", instr_valid, instr_pc, instr_data, mem_word(32'h0));
    else n_pass++;
    step(1);
    instr_ready = 1'b1;
    wait_pops(4, 40);
    n_checks++;
    if (pop_log.size() < 4) $display("FAIL bp_drain_timeout: got %0d instrs, required 4", pop_log.size());
    else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8 || pop_log[3] !== 32'hC)
      $display("FAIL bp_drain_order: got %h %h %h %h, required 0 4 8 c", pop_log[0], pop_log[1], pop_log[2], pop_log[3]);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int a0, k;
    data_is_addr = 0; mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    a0 = acc_count;
    k = 0;
    while (acc_count - a0 < 2 && k < 40) begin step(1); k++; end
    n_checks++;
    if (acc_count - a0 < 2) $display("FAIL rw_timeout: got %0d requests, required 2", acc_count - a0);
    else n_pass++;
    do_redirect(32'h0000_0103);
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rw_flush: got instr_valid=%b, required 0", instr_valid); else n_pass++;
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rw_drop_req: got req_valid=%b, required 0", imem_req_valid); else n_pass++;
    step(1);
    instr_ready = 1'b1;
    wait_pops(1, 40);
    n_checks++;
    if (acc_log.size() < 1 || pop_log.size() < 1)
      $display("FAIL rw_restart: got %0d requests %0d instrs, required at least 1 each", acc_log.size(), pop_log.size());
    else if (acc_log[0] !== 32'h100 || pop_log[0] !== 32'h100)
      $display("FAIL rw_restart: got req %h instr_pc %h, required 100 100", acc_log[0], pop_log[0]);
    else n_pass++;
  endtask

  task automatic test_redirect_rsp();
    int a0, k;
    logic [W-1:0] tgt;
    data_is_addr = 0; mem_lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    a0 = acc_count;
    k = 0;
    while (acc_count - a0 < 2 && k < 40) begin step(1); k++; end
    step(1);
    tgt = $urandom;
    do_redirect(tgt);
    wait_pops(2, 40);
    n_checks++;
    if (acc_log.size() < 1 || pop_log.size() < 2)
      $display("FAIL rr_restart: got %0d requests %0d instrs, required 1 and 2", acc_log.size(), pop_log.size());
    else if (acc_log[0] !== {tgt[W-1:2], 2'b00} || pop_log[0] !== {tgt[W-1:2], 2'b00} || pop_log[1] !== {tgt[W-1:2], 2'b00} + 32'd4)
      $display("FAIL rr_restart: got req %h instr_pc %h %h, required %h", acc_log[0], pop_log[0], pop_log[1], {tgt[W-1:2], 2'b00});
    else n_pass++;
  endtask

  task automatic test_stall();
    int k;
    logic [W-1:0] tgt;
    data_is_addr = 0; mem_lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
    apply_reset();
    k = 0;
    while (imem_req_valid !== 1'b1 && k < 10) begin step(1); k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
        $display("FAIL stall_hold: cycle %0d valid=%b addr=%h, required 1 %h", i, imem_req_valid, imem_req_addr, RST_PC);
      else n_pass++;
    end
    step(1);
    tgt = $urandom;
    do_redirect(tgt);
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== {tgt[W-1:2], 2'b00})
      $display("FAIL stall_redirect: valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, {tgt[W-1:2], 2'b00});
    else n_pass++;
    step(1);
    imem_req_ready = 1'b1;
    wait_pops(1, 20);
    n_checks++;
    if (pop_log.size() < 1) $display("FAIL stall_no_drop: got 0 instrs, required 1");
    else if (pop_log[0] !== {tgt[W-1:2], 2'b00})
      $display("FAIL stall_no_drop: got pc %h, required %h", pop_log[0], {tgt[W-1:2], 2'b00});
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    int a0, k;
    data_is_addr = 0; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    do_redirect(32'hFFFF_FFFF);
    wait_pops(2, 30);
    n_checks++;
    if (pop_log.size() < 2) $display("FAIL wrap_timeout: got %0d instrs, required 2", pop_log.size());
    else if (pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0)
      $display("FAIL wrap_order: got %h %h, required fffffffc 0", pop_log[0], pop_log[1]);
    else n_pass++;
    mem_lat = 3;
    a0 = acc_count;
    k = 0;
    while (acc_count == a0 && k < 20) begin step(1); k++; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || instr_valid !== 1'b0 || instr_data !== '0 || instr_pc !== '0)
      $display("FAIL async_reset: req_valid=%b addr=%h instr_valid=%b data=%h pc=%h, required 0 %h 0 0 0", imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, RST_PC);
    else n_pass++;
    step(2);
  endtask

  task automatic test_random();
    int p0, a0;
    data_is_addr = 0; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    p0 = 0;
    a0 = acc_count;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      p0 = p0 + pop_log.size();
      pop_log.delete();
      step(1);
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b1;
    step(20);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || instr_valid !== 1'b0)
      $display("FAIL rand_drain: %0d expected instrs undelivered, instr_valid=%b, required 0 0", exp_q.size(), instr_valid);
    else n_pass++;
    n_checks++;
    if (acc_count - a0 < 300 || p0 < 200)
      $display("FAIL rand_progress: got %0d requests %0d instrs, required >=300 >=200", acc_count - a0, p0);
    else n_pass++;
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_stall();
    test_wrap_reset();
    test_random();
    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
